tekipaki_gfx_arbiter: RTL and testbench
=======================================

# tekipaki_gfx_arbiter

Shares one 16-bit SDRAM read bank among the four GP9001 graphics fetch clients: sprite GFX, SCR0, SCR1 and SCR2. It sits between `raizing_video` and the bank port of `tekipaki_sdram`. Each 32-bit client read is split into two 16-bit bank reads and reassembled. Each client keeps a one-entry hit buffer, so a repeated address returns data without a bank access.

## Interface
- No parameters. Client count (4) and widths are fixed.
- `CLK` in 1: system clock. Every register in the block is clocked by it.
- `RESET` in 1: synchronous, active-high reset.
- `CS` in 4: client request lines; bit 0 = sprite, bits 1–3 = SCR0–SCR2.
- `ADDR0`..`ADDR3` in 22 each: client halfword address of the low half. Bit 0 is ignored and treated as 0.
- `DOUT0`..`DOUT3` out 32 each: client data, `{hi,lo}`.
- `OK` out 4: per-client data valid.
- `BA_ADDR` out 22: bank halfword address.
- `BA_RD` out 1: bank read request.
- `BA_ACK` in 1: bank accepted the request.
- `BA_RDY` in 1: single-cycle pulse; `DATA_READ` is valid in that cycle.
- `DATA_READ` in 16: bank read data.

## Operation
- **Per-client buffer:** `tag[21:1]`, `valid`, `data[31:0]`.
  - `OK[i]` = `CS[i] & valid[i] & (tag[i] == ADDR_i[21:1])`. This is combinational from registers and inputs.
  - `DOUT_i` = `data[i]` at all times.
- **Miss:** `CS[i]` high and not a hit.
- **FSM states:**
  - `IDLE`: if any client misses, pick a grant `g`, latch `a = ADDR_g[21:1]`, then go to `RD_LO`. Otherwise stay in `IDLE`.
  - `RD_LO`: `BA_ADDR = {a,1'b0}`, `BA_RD = 1`. On `BA_ACK`, go to `WT_LO`.
  - `WT_LO`: `BA_RD = 0`. On `BA_RDY`, store `lo = DATA_READ`, go to `RD_HI`.
  - `RD_HI`: `BA_ADDR = {a,1'b1}`, `BA_RD = 1`. On `BA_ACK`, go to `WT_HI`.
  - `WT_HI`: on `BA_RDY`, write `data[g] = {DATA_READ,lo}`, `tag[g] = a`, `valid[g] = 1`, then go to `IDLE`.
- **Arbitration:** round-robin among missing clients. The search starts at `last_grant + 1` mod 4; `last_grant` updates on each grant.
- **CS dropped or ADDR changed mid-fetch:** the fetch completes and fills the buffer under the latched `a`. `OK` follows the hit equation, so it stays low if the address now differs. A changed address becomes a new miss.
- **Buffer writes:** `valid[i]` is never cleared except by `RESET`. The ROM is read-only, so no invalidation is needed.
- **RESET** (any state): go to `IDLE`, `BA_RD = 0`, `BA_ADDR = 0`, `valid = 0`, `data = 0`, `tag = 0`, `last_grant = 3` (so client 0 wins first), `OK = 0`.

## Timing
- **Hit:** `OK` is high in the same cycle that `CS`/`ADDR` present a matching address. Zero latency.
- **Miss, bank ACK and RDY each one cycle after request** (cycle 0 = `CS` high in `IDLE`):
  - `BA_RD` high at cycle 1; `ACK` at 1.
  - `RDY` at 2 or later; `BA_RD` high again at 3; `ACK` at 3.
  - `RDY` at 4; `OK` high at cycle 5.
  - Minimum miss latency: 5 cycles.
- **BA_RD rules:** held high until `ACK` is sampled, low on the cycle after. It is never high in `WT_*` or `IDLE`.
- **BA_ADDR:** stable from entry into `RD_x` until `ACK`.
- **BA_RDY outside WT_LO / WT_HI:** ignored.
- **Back-to-back requests:** a new grant can be made in the `IDLE` cycle that follows `WT_HI`.

## Configuration
- `TEKIPAKI_GFX_SPRPRI_EN`
  - **Defined:** a missing client 0 (sprite) always wins in `IDLE`. Clients 1–3 round-robin among themselves only when client 0 is not missing. `last_grant` tracks only grants to clients 1–3.
  - **Undefined:** pure 4-way round-robin as described above.

## Test plan
- **Reset then single miss.** Stimulus: `RESET` 1 cycle; then `CS = 0001`, `ADDR0 = 22'h000100`; bank returns `16'h1234` then `16'h5678`, each with ACK same cycle and RDY next cycle. Required: `BA_ADDR = 0x100` then `0x101`; `OK[0]` rises at cycle 5 with `DOUT0 = 32'h56781234`.
- **Hit.** Stimulus: re-present `ADDR0 = 0x100` after an idle gap. Required: `OK[0] = 1` in the same cycle; `BA_RD` stays 0.
- **Round-robin.** Stimulus: `CS = 1111`, all misses, distinct addresses. Required: grant order 0, 1, 2, 3. Then clear client 2's buffer via `RESET`, re-request with `CS = 0101`. Required: after reset, client 0 is served before client 2.
- **Address change mid-fetch.** Stimulus: `ADDR1` changes from `0x200` to `0x300` during `WT_LO`. Required: the `0x200` fetch completes; `OK[1]` stays 0 and a second fetch of `0x300` starts. `OK[1]` rises only after the `0x300` fetch completes.
- **Reset mid-fetch.** Stimulus: `RESET` asserted in `RD_HI`. Required: next cycle `BA_RD = 0` and `OK = 0000`; a previously cached address now misses.
- **SPRPRI (macro defined).** Stimulus: clients 1 and 0 both missing in `IDLE`, with `last_grant = 0`. Required: client 0 is granted first.

Source files
------------

// File: rtl/tekipaki_gfx_arbiter.sv
// tekipaki_gfx_arbiter
//   Shares one 16-bit SDRAM read bank among the four GP9001 graphics fetch
//   clients (sprite, SCR0, SCR1, SCR2). Each 32-bit client read becomes two
//   16-bit bank reads (low halfword first). The two halves are reassembled
//   into a one-entry hit buffer per client, so a repeated address returns
//   data with zero latency and no bank access.
//
// Ports
//   CLK              system clock
//   RESET            synchronous, active-high reset
//   CS[3:0]          client request lines (bit 0 sprite, bits 1-3 SCR0-SCR2)
//   ADDR0..ADDR3     client halfword address of the low half (bit 0 ignored)
//   DOUT0..DOUT3     client data {hi,lo}, always the buffered word
//   OK[3:0]          per-client hit (data valid for the presented address)
//   BA_ADDR          bank halfword address
//   BA_RD            bank read request, held until BA_ACK is sampled
//   BA_ACK           bank accepted the request
//   BA_RDY           single-cycle pulse, DATA_READ valid in that cycle
//   DATA_READ        bank read data
//
// Build option
//   TEKIPAKI_GFX_SPRPRI_EN  when defined, a missing sprite client always wins
//                           and clients 1-3 round-robin among themselves.
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a miss; grant and latch the address
//   RD_LO | requesting the low halfword
//   WT_LO | waiting for low halfword data
//   RD_HI | requesting the high halfword
//   WT_HI | waiting for high halfword data, then fill the buffer

module tekipaki_gfx_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  CS,
  input  logic [21:0] ADDR0,
  input  logic [21:0] ADDR1,
  input  logic [21:0] ADDR2,
  input  logic [21:0] ADDR3,
  output logic [31:0] DOUT0,
  output logic [31:0] DOUT1,
  output logic [31:0] DOUT2,
  output logic [31:0] DOUT3,
  output logic [3:0]  OK,
  output logic [21:0] BA_ADDR,
  output logic        BA_RD,
  input  logic        BA_ACK,
  input  logic        BA_RDY,
  input  logic [15:0] DATA_READ
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    WT_LO = 3'd2,
    RD_HI = 3'd3,
    WT_HI = 3'd4
  } state_t;

  state_t      state_q;
  logic [20:0] tag_q  [4];
  logic [31:0] data_q [4];
  logic [3:0]  valid_q;
  logic [1:0]  grant_q;
  logic [1:0]  last_q;
  logic [20:0] a_q;
  logic [15:0] lo_q;
  logic        ba_rd_q;
  logic [21:0] ba_addr_q;

  logic [20:0] req_addr [4];
  logic [3:0]  hit;
  logic [3:0]  miss;
  logic [1:0]  grant_d;
  logic [1:0]  cand;
  logic        found;

  // Address bit 0 selects a halfword inside the 32-bit word and is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ADDR0[0] ^ ADDR1[0] ^ ADDR2[0] ^ ADDR3[0];

  assign req_addr[0] = ADDR0[21:1];
  assign req_addr[1] = ADDR1[21:1];
  assign req_addr[2] = ADDR2[21:1];
  assign req_addr[3] = ADDR3[21:1];

  always_comb begin
    hit = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = CS[i] & valid_q[i] & (tag_q[i] == req_addr[i]);
    end
    miss = CS & ~hit;
  end

  // Round-robin search starting one past the last grant.
  always_comb begin
    grant_d = last_q;
    found   = 1'b0;
    cand    = '0;
`ifdef TEKIPAKI_GFX_SPRPRI_EN
    if (miss[0]) begin
      grant_d = 2'd0;
      found   = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        cand = last_q + 2'(k);
        if (!found && (cand != 2'd0) && miss[cand]) begin
          grant_d = cand;
          found   = 1'b1;
        end
      end
    end
`else
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && miss[cand]) begin
        grant_d = cand;
        found   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      grant_q   <= '0;
      last_q    <= 2'd3;
      a_q       <= '0;
      lo_q      <= '0;
      ba_rd_q   <= 1'b0;
      ba_addr_q <= '0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q   <= grant_d;
            a_q       <= req_addr[grant_d];
            ba_addr_q <= {req_addr[grant_d], 1'b0};
            ba_rd_q   <= 1'b1;
            state_q   <= RD_LO;
`ifdef TEKIPAKI_GFX_SPRPRI_EN
            // Sprite grants do not disturb the SCR rotation.
            if (grant_d != 2'd0) last_q <= grant_d;
`else
            last_q    <= grant_d;
`endif
          end
        end
        RD_LO: begin
          if (BA_ACK) begin
            ba_rd_q <= 1'b0;
            state_q <= WT_LO;
          end
        end
        WT_LO: begin
          if (BA_RDY) begin
            lo_q      <= DATA_READ;
            ba_addr_q <= {a_q, 1'b1};
            ba_rd_q   <= 1'b1;
            state_q   <= RD_HI;
          end
        end
        RD_HI: begin
          if (BA_ACK) begin
            ba_rd_q <= 1'b0;
            state_q <= WT_HI;
          end
        end
        WT_HI: begin
          if (BA_RDY) begin
            // Fill under the latched address even if the client moved on.
            data_q[grant_q]  <= {DATA_READ, lo_q};
            tag_q[grant_q]   <= a_q;
            valid_q[grant_q] <= 1'b1;
            state_q          <= IDLE;
          end
        end
        default: begin
          ba_rd_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign OK      = hit;
  assign DOUT0   = data_q[0];
  assign DOUT1   = data_q[1];
  assign DOUT2   = data_q[2];
  assign DOUT3   = data_q[3];
  assign BA_RD   = ba_rd_q;
  assign BA_ADDR = ba_addr_q;

endmodule

// File: tb/tb_tekipaki_gfx_arbiter.sv
module tb_tekipaki_gfx_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  CS = '0;
  logic [21:0] ADDR0 = '0, ADDR1 = '0, ADDR2 = '0, ADDR3 = '0;
  logic [31:0] DOUT0, DOUT1, DOUT2, DOUT3;
  logic [3:0]  OK;
  logic [21:0] BA_ADDR;
  logic        BA_RD;
  logic        BA_ACK = 1'b0;
  logic        BA_RDY = 1'b0;
  logic [15:0] DATA_READ = '0;

  tekipaki_gfx_arbiter dut (
    .CLK(CLK), .RESET(RESET), .CS(CS),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3),
    .DOUT0(DOUT0), .DOUT1(DOUT1), .DOUT2(DOUT2), .DOUT3(DOUT3),
    .OK(OK), .BA_ADDR(BA_ADDR), .BA_RD(BA_RD), .BA_ACK(BA_ACK),
    .BA_RDY(BA_RDY), .DATA_READ(DATA_READ)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ROM contents seen through the bank
  function automatic logic [15:0] rom(input logic [21:0] a);
    logic [21:0] t;
    t = a * 22'd40503;
    return t[15:0] ^ {a[21:16], a[9:0]};
  endfunction

  // staged client inputs, applied on the next falling edge
  logic        rst_stg = 1'b1;
  logic [3:0]  cs_stg  = '0;
  logic [21:0] addr_stg [4] = '{default: '0};

  // bank responder
  logic        fast_bank = 1'b1;
  logic        bk_busy = 1'b0;
  int          bk_cnt  = 0;
  logic [21:0] bk_addr = '0;

  // reference model: per-client caches plus one in-flight fetch transaction
  logic        m_valid [4] = '{default: 1'b0};
  logic [20:0] m_tag   [4] = '{default: '0};
  logic [31:0] m_data  [4] = '{default: '0};
  int          m_last  = 3;
  logic        f_active = 1'b0;
  logic        f_req    = 1'b0;
  logic        f_hi     = 1'b0;
  int          f_g      = 0;
  logic [20:0] f_a      = '0;
  logic [15:0] f_lo     = '0;

  logic        checks_en = 1'b0;
  logic        prev_rd = 1'b0;
  logic [20:0] fetch_log [$];

  function automatic logic [21:0] addr_in(input int i);
    case (i)
      0: return ADDR0;
      1: return ADDR1;
      2: return ADDR2;
      default: return ADDR3;
    endcase
  endfunction

  function automatic logic [31:0] dout_of(input int i);
    case (i)
      0: return DOUT0;
      1: return DOUT1;
      2: return DOUT2;
      default: return DOUT3;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] mv, input int last);
`ifdef TEKIPAKI_GFX_SPRPRI_EN
    int c;
    if (mv[0]) return 0;
    for (int k = 1; k <= 3; k++) begin
      c = ((last + k - 1) % 3) + 1;
      if (mv[c]) return c;
    end
    return -1;
`else
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (last + k) % 4;
      if (mv[c]) return c;
    end
    return -1;
`endif
  endfunction

  task automatic tick();
    logic [3:0]  ok_exp;
    logic [3:0]  mv;
    logic [21:0] ad;
    int          g;
    @(negedge CLK);
    RESET = rst_stg;
    CS    = cs_stg;
    ADDR0 = addr_stg[0];
    ADDR1 = addr_stg[1];
    ADDR2 = addr_stg[2];
    ADDR3 = addr_stg[3];
    BA_ACK    = 1'b0;
    BA_RDY    = 1'b0;
    DATA_READ = 16'($urandom);
    if (rst_stg) begin
      bk_busy = 1'b0;
    end else if (bk_busy) begin
      bk_cnt--;
      if (bk_cnt == 0) begin
        BA_RDY    = 1'b1;
        DATA_READ = rom(bk_addr);
        bk_busy   = 1'b0;
      end
    end else if (BA_RD && (fast_bank || $urandom_range(0, 2) != 0)) begin
      BA_ACK  = 1'b1;
      bk_busy = 1'b1;
      bk_addr = BA_ADDR;
      bk_cnt  = fast_bank ? 1 : int'($urandom_range(1, 3));
    end else if (!fast_bank && $urandom_range(0, 7) == 0) begin
      BA_RDY = 1'b1;  // stray pulse with no read outstanding
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      ad = addr_in(i);
      ok_exp[i] = CS[i] & m_valid[i] & (m_tag[i] == ad[21:1]);
    end
    if (checks_en) begin
      check_val("ok", 32'(OK), 32'(ok_exp));
      check_val("ba_rd", 32'(BA_RD), 32'(f_active & f_req));
      if (f_active && f_req) check_val("ba_addr", 32'(BA_ADDR), 32'({f_a, f_hi}));
      for (int i = 0; i < 4; i++)
        if (ok_exp[i]) check_val($sformatf("dout%0d", i), dout_of(i), m_data[i]);
    end
    if (BA_RD && !prev_rd && !BA_ADDR[0]) fetch_log.push_back(BA_ADDR[21:1]);
    prev_rd = BA_RD;
    // advance the model across the coming rising edge
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0;
        m_tag[i]   = '0;
        m_data[i]  = '0;
      end
      m_last = 3;
      f_active = 1'b0;
      f_req = 1'b0;
      f_hi = 1'b0;
    end else if (!f_active) begin
      mv = CS & ~ok_exp;
      if (mv != 4'b0) begin
        g  = pick(mv, m_last);
        ad = addr_in(g);
        f_g = g;
        f_a = ad[21:1];
        f_active = 1'b1;
        f_req = 1'b1;
        f_hi = 1'b0;
`ifdef TEKIPAKI_GFX_SPRPRI_EN
        if (g != 0) m_last = g;
`else
        m_last = g;
`endif
      end
    end else if (f_req) begin
      if (BA_ACK) f_req = 1'b0;
    end else if (BA_RDY) begin
      if (!f_hi) begin
        f_lo = DATA_READ;
        f_hi = 1'b1;
        f_req = 1'b1;
      end else begin
        m_data[f_g]  = {DATA_READ, f_lo};
        m_tag[f_g]   = f_a;
        m_valid[f_g] = 1'b1;
        f_active = 1'b0;
      end
    end
    checks_en = 1'b1;
  endtask

  task automatic do_reset();
    rst_stg = 1'b1;
    cs_stg  = '0;
    tick();
    rst_stg = 1'b0;
  endtask

  task automatic wait_ok(input int idx, input int lim, input string tag);
    int n;
    n = 0;
    while (!OK[idx] && n < lim) begin
      tick();
      n++;
    end
    if (!OK[idx]) check_val(tag, 32'(OK[idx]), 32'd1);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (f_active && n < lim) begin
      tick();
      n++;
    end
    if (f_active) check_val("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    logic got;

    // reset state and single miss with minimum bank latency
    fast_bank = 1'b1;
    do_reset();
    tick();
    check_val("rst_ba_addr", 32'(BA_ADDR), 32'd0);
    check_val("rst_dout0", DOUT0, 32'd0);
    check_val("rst_dout3", DOUT3, 32'd0);
    check_val("rst_ok", 32'(OK), 32'd0);
    fetch_log.delete();
    cs_stg = 4'b0001;
    addr_stg[0] = 22'h000100;
    got = 1'b0;
    n = 0;
    for (int c = 0; c <= 20; c++) begin
      tick();
      if (OK[0]) begin
        got = 1'b1;
        n = c;
        break;
      end
    end
    check_val("miss_seen", 32'(got), 32'd1);
    check_val("miss_latency", n, 32'd5);
    check_val("miss_dout0", DOUT0, {rom(22'h000101), rom(22'h000100)});
    check_val("miss_fetches", fetch_log.size(), 32'd1);

    // hit after idle gap
    cs_stg = '0;
    repeat (3) tick();
    cs_stg = 4'b0001;
    tick();
    check_val("hit_ok0", 32'(OK[0]), 32'd1);
    tick();
    check_val("hit_no_rd", 32'(BA_RD), 32'd0);

    // round-robin from reset: 0,1,2,3
    do_reset();
    fetch_log.delete();
    cs_stg = 4'b1111;
    addr_stg[0] = 22'h000120;
    addr_stg[1] = 22'h000220;
    addr_stg[2] = 22'h000320;
    addr_stg[3] = 22'h000420;
    wait_ok(3, 80, "rr_timeout");
    tick();
    check_val("rr_count", fetch_log.size(), 32'd4);
    if (fetch_log.size() == 4) begin
      check_val("rr_g0", 32'(fetch_log[0]), 32'h90);
      check_val("rr_g1", 32'(fetch_log[1]), 32'h110);
      check_val("rr_g2", 32'(fetch_log[2]), 32'h190);
      check_val("rr_g3", 32'(fetch_log[3]), 32'h210);
    end
    do_reset();
    fetch_log.delete();
    cs_stg = 4'b0101;
    wait_ok(2, 60, "rr2_timeout");
    check_val("rr2_count", fetch_log.size(), 32'd2);
    if (fetch_log.size() == 2) begin
      check_val("rr2_first", 32'(fetch_log[0]), 32'h90);
      check_val("rr2_second", 32'(fetch_log[1]), 32'h190);
    end

    // address change during low-half wait
    do_reset();
    fetch_log.delete();
    cs_stg = 4'b0010;
    addr_stg[1] = 22'h000200;
    n = 0;
    while (!(f_active && !f_req && !f_hi) && n < 20) begin
      tick();
      n++;
    end
    check_val("chg_reached_wt_lo", 32'(f_active && !f_req && !f_hi), 32'd1);
    addr_stg[1] = 22'h000300;
    wait_ok(1, 60, "chg_timeout");
    check_val("chg_fetches", fetch_log.size(), 32'd2);
    if (fetch_log.size() == 2) begin
      check_val("chg_first", 32'(fetch_log[0]), 32'h100);
      check_val("chg_second", 32'(fetch_log[1]), 32'h180);
    end
    check_val("chg_dout1", DOUT1, {rom(22'h000301), rom(22'h000300)});

    // reset in the high-half request
    do_reset();
    cs_stg = 4'b0001;
    addr_stg[0] = 22'h000100;
    wait_ok(0, 40, "pre_timeout");
    cs_stg = 4'b0011;
    addr_stg[1] = 22'h000400;
    n = 0;
    while (!(f_active && f_req && f_hi) && n < 20) begin
      tick();
      n++;
    end
    check_val("mid_reached_rd_hi", 32'(f_active && f_req && f_hi), 32'd1);
    rst_stg = 1'b1;
    tick();
    rst_stg = 1'b0;
    tick();
    check_val("mid_rst_rd", 32'(BA_RD), 32'd0);
    check_val("mid_rst_ok", 32'(OK), 32'd0);
    wait_idle(40);

    // sprite and SCR0 missing together
    do_reset();
    fetch_log.delete();
    cs_stg = 4'b0011;
    addr_stg[0] = 22'h000500;
    addr_stg[1] = 22'h000600;
    wait_ok(1, 60, "pri_timeout");
    if (fetch_log.size() >= 1) check_val("pri_first", 32'(fetch_log[0]), 32'h280);
    else check_val("pri_count", fetch_log.size(), 32'd2);

    // randomized traffic with a slow, jittery bank
    fast_bank = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) cs_stg[i] = ~cs_stg[i];
        if ($urandom_range(0, 7) == 0)
          addr_stg[i] = 22'h000100 + 22'($urandom_range(0, 5) * 2 + $urandom_range(0, 1))
                        + 22'(i) * 22'h40;
      end
      rst_stg = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst_stg = 1'b0;
    cs_stg = '0;
    wait_idle(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
